// File: rtl/instruction_fetch_unit.sv
// IF stage: owns the PC, stalls on instruction-cache misses, applies EX redirects
// (deferring them until an outstanding miss completes) and loads the IF/ID register.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CACHE_BUSYWAIT,
  input  logic [31:0] CACHE_READDATA,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] BRANCH_TARGET,
  input  logic        STALL,
  output logic [31:0] CACHE_ADDRESS,
  output logic [31:0] IF_ID_PC,
  output logic [31:0] IF_ID_PC4,
  output logic [31:0] IF_ID_INSTRUCTION,
  output logic        IF_ID_VALID,
  output logic        FETCH_STALL
);

  typedef enum logic {FETCH, REDIRECT_PENDING} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic [31:0] ifpc_q, ifpc_d;
  logic [31:0] ifpc4_q, ifpc4_d;
  logic [31:0] ins_q, ins_d;
  logic        vld_q, vld_d;
  logic [31:0] tgt_al;

  assign tgt_al = {BRANCH_TARGET[31:2], 2'b00};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    ifpc_d  = ifpc_q;
    ifpc4_d = ifpc4_q;
    ins_d   = ins_q;
    vld_d   = vld_q;
    case (state_q)
      FETCH: begin
        if (BRANCH_TAKEN && !CACHE_BUSYWAIT) begin
          pc_d  = tgt_al;
          vld_d = 1'b0;
          ins_d = NOP_INSTR;
        end else if (BRANCH_TAKEN) begin
          // Hold PC so the cache can finish the miss it is servicing.
          pend_d  = tgt_al;
          state_d = REDIRECT_PENDING;
          vld_d   = 1'b0;
          ins_d   = NOP_INSTR;
        end else if (CACHE_BUSYWAIT) begin
          if (!STALL) begin
            vld_d = 1'b0;
            ins_d = NOP_INSTR;
          end
        end else if (!STALL) begin
          ifpc_d  = pc_q;
          ifpc4_d = pc_q + 32'd4;
          ins_d   = CACHE_READDATA;
          vld_d   = 1'b1;
          pc_d    = pc_q + 32'd4;
        end
      end
      default: begin
        if (!STALL) begin
          vld_d = 1'b0;
          ins_d = NOP_INSTR;
        end
        if (BRANCH_TAKEN) pend_d = tgt_al;
        // Data returned for the old PC is dropped; jump to the latest target.
        if (!CACHE_BUSYWAIT) begin
          pc_d    = BRANCH_TAKEN ? tgt_al : pend_q;
          state_d = FETCH;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= FETCH;
      pc_q    <= RESET_VECTOR;
      pend_q  <= 32'h0;
      ifpc_q  <= 32'h0;
      ifpc4_q <= 32'h0;
      ins_q   <= NOP_INSTR;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      ifpc_q  <= ifpc_d;
      ifpc4_q <= ifpc4_d;
      ins_q   <= ins_d;
      vld_q   <= vld_d;
    end
  end

  assign CACHE_ADDRESS     = pc_q;
  assign IF_ID_PC          = ifpc_q;
  assign IF_ID_PC4         = ifpc4_q;
  assign IF_ID_INSTRUCTION = ins_q;
  assign IF_ID_VALID       = vld_q;
  assign FETCH_STALL       = CACHE_BUSYWAIT | (state_q == REDIRECT_PENDING);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed test-plan scenarios with literal
// expectations, then randomized traffic checked every cycle against a behavioural model.
module tb_instruction_fetch_unit;
  localparam logic [31:0] RV  = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n, bw, bt, st;
  logic [31:0] tgt, rd;
  logic [31:0] addr, ifpc, ifpc4, ins;
  logic        vld, fstall;

  int n_cmp = 0;
  int n_err = 0;

  // model state
  logic [31:0] m_pc, m_pt, m_ifpc, m_ifpc4, m_ins;
  logic        m_pend, m_vld;

  always #5 clk = ~clk;

  // Instruction memory image: each word encodes its own address.
  assign rd = 32'h1000_0000 | addr;

  instruction_fetch_unit #(.RESET_VECTOR(RV), .NOP_INSTR(NOP)) dut (
    .CLK(clk), .RESET(rst_n), .CACHE_BUSYWAIT(bw), .CACHE_READDATA(rd),
    .BRANCH_TAKEN(bt), .BRANCH_TARGET(tgt), .STALL(st),
    .CACHE_ADDRESS(addr), .IF_ID_PC(ifpc), .IF_ID_PC4(ifpc4),
    .IF_ID_INSTRUCTION(ins), .IF_ID_VALID(vld), .FETCH_STALL(fstall)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Spec rules applied to the model for one rising edge.
  task automatic model_edge(input logic r, input logic b, input logic [31:0] t,
                            input logic w, input logic s);
    logic [31:0] ta;
    ta = t & 32'hFFFF_FFFC;
    if (!r) begin
      m_pc = RV; m_pend = 1'b0; m_pt = 32'h0;
      m_ifpc = 32'h0; m_ifpc4 = 32'h0; m_ins = NOP; m_vld = 1'b0;
    end else if (!m_pend) begin
      if (b && !w) begin
        m_pc = ta; m_vld = 1'b0; m_ins = NOP;
      end else if (b) begin
        m_pt = ta; m_pend = 1'b1; m_vld = 1'b0; m_ins = NOP;
      end else if (w) begin
        if (!s) begin m_vld = 1'b0; m_ins = NOP; end
      end else if (!s) begin
        m_ifpc = m_pc; m_ifpc4 = m_pc + 32'd4;
        m_ins = 32'h1000_0000 | m_pc; m_vld = 1'b1;
        m_pc = m_pc + 32'd4;
      end
    end else begin
      if (!s) begin m_vld = 1'b0; m_ins = NOP; end
      if (b) m_pt = ta;
      if (!w) begin m_pc = m_pt; m_pend = 1'b0; end
    end
  endtask

  task automatic cyc(input logic r, input logic b, input logic [31:0] t,
                     input logic w, input logic s);
    rst_n = r; bt = b; tgt = t; bw = w; st = s;
    #1;
    chk("fetch_stall", {31'b0, fstall}, {31'b0, w | m_pend});
    @(posedge clk);
    model_edge(r, b, t, w, s);
    @(negedge clk);
    chk("cache_address", addr, m_pc);
    chk("if_id_pc", ifpc, m_ifpc);
    chk("if_id_pc4", ifpc4, m_ifpc4);
    chk("if_id_instr", ins, m_ins);
    chk("if_id_valid", {31'b0, vld}, {31'b0, m_vld});
  endtask

  initial begin
    rst_n = 1'b0; bw = 1'b0; bt = 1'b0; st = 1'b0; tgt = 32'h0;
    m_pc = RV; m_pend = 1'b0; m_pt = 0; m_ifpc = 0; m_ifpc4 = 0; m_ins = NOP; m_vld = 0;

    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("rst_addr", addr, 32'h0);
    chk("rst_valid", {31'b0, vld}, 32'h0);
    chk("rst_instr", ins, 32'h13);

    // sequential hits from reset
    cyc(1, 0, 0, 0, 0);
    chk("tp1_pc0", ifpc, 32'h0);
    chk("tp1_instr0", ins, 32'h1000_0000);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("tp1_pc8", ifpc, 32'h8);
    chk("tp1_pc4", ifpc4, 32'hC);
    chk("tp1_valid", {31'b0, vld}, 32'h1);

    // redirect on a hit, target misaligned
    cyc(1, 1, 32'h43, 0, 0);
    chk("tp3_addr", addr, 32'h40);
    chk("tp3_bubble", {31'b0, vld}, 32'h0);
    cyc(1, 0, 0, 0, 0);
    chk("tp3_pc", ifpc, 32'h40);
    chk("tp3_valid", {31'b0, vld}, 32'h1);

    // 3-cycle miss at 0x10
    cyc(1, 1, 32'h10, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 1, 0);
      chk("tp2_addr_hold", addr, 32'h10);
      chk("tp2_nop", ins, 32'h13);
    end
    cyc(1, 0, 0, 0, 0);
    chk("tp2_pc", ifpc, 32'h10);
    chk("tp2_next_addr", addr, 32'h14);

    // redirect during a miss
    cyc(1, 1, 32'h20, 0, 0);
    cyc(1, 1, 32'h80, 1, 0);
    chk("tp4_hold1", addr, 32'h20);
    cyc(1, 0, 0, 1, 0);
    chk("tp4_hold2", addr, 32'h20);
    cyc(1, 0, 0, 0, 0);
    chk("tp4_addr", addr, 32'h80);
    chk("tp4_discard", {31'b0, vld}, 32'h0);
    cyc(1, 0, 0, 0, 0);
    chk("tp4_pc", ifpc, 32'h80);

    // stalls
    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    chk("tp5_addr", addr, 32'h84);
    chk("tp5_pc", ifpc, 32'h80);
    cyc(1, 0, 0, 1, 1);
    chk("tp5_held_valid", {31'b0, vld}, 32'h1);
    chk("tp5_held_pc", ifpc, 32'h80);

    // wrap and reset during a miss
    cyc(1, 1, 32'hFFFF_FFFF, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("tp6_wrap_addr", addr, 32'h0);
    chk("tp6_wrap_pc4", ifpc4, 32'h0);
    cyc(1, 1, 32'h30, 0, 0);
    cyc(1, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    chk("tp6_rst_addr", addr, RV);
    chk("tp6_rst_valid", {31'b0, vld}, 32'h0);
    cyc(1, 0, 0, 0, 0);
    chk("tp6_after_rst", ifpc, RV);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic r, b, w, s;
      logic [31:0] t;
      r = ($urandom_range(199) != 0);
      b = ($urandom_range(7) == 0);
      w = ($urandom_range(3) == 0);
      s = ($urandom_range(5) == 0);
      t = ($urandom_range(9) == 0) ? (32'hFFFF_FFF0 | $urandom_range(15)) : $urandom;
      cyc(r, b, t, w, s);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
